sprite_mover: RTL and testbench
===============================

Name: sprite_mover

Overview:
Parametrised per-sprite position engine, successor to the fixed four-flag Pac-Man location register. Holds a current heading and buffers one requested turn. On each move tick it asks the maze wall lookup, over a req/ack handshake, whether the target cell is free, then commits the step with tunnel wrap-around. One instance is used per sprite (Pac-Man and ghosts), each with its own start cell.

Parameters:
WIDTH, 96, playfield columns; legal x is 1..WIDTH
HEIGHT, 72, playfield rows; legal y is 1..HEIGHT
XW, 10, x coordinate width; must hold WIDTH
YW, 9, y coordinate width; must hold HEIGHT
X_START, 46, x loaded on reset and on start
Y_START, 7, y loaded on reset and on start
ACK_TIMEOUT, 15, max cycles to wait for wall_ack; used only with SPRITE_ACK_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  synchronous reload of start position; aborts any operation in progress
tick  in  1  single-cycle move strobe
dir_valid  in  1  dir_in is a new requested heading
dir_in  in  2  0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1)
wall_req  out  1  wall query valid; held until wall_ack
wall_x  out  XW  queried target x, already wrapped
wall_y  out  YW  queried target y, already wrapped
wall_ack  in  1  query answered this cycle
wall_blocked  in  1  qualified by wall_ack; 1 = target cell is a wall
x_loc  out  XW  current x
y_loc  out  YW  current y
dir_cur  out  2  current heading
moving  out  1  sprite is in motion along dir_cur
move_done  out  1  one-cycle pulse when a step is committed
tick_drop  out  1  one-cycle pulse when a tick arrives outside IDLE
ack_err  out  1  one-cycle timeout pulse (optional feature only)

Behaviour:
- Reset (async assert, sync release internally not required): x_loc=X_START, y_loc=Y_START, dir_cur=0, moving=0, pending turn empty, FSM=IDLE. All pulse outputs and wall_req are 0.
- start (sync): has the same effect as reset, from any state. wall_req drops the next cycle. A wall_ack arriving afterwards is ignored.
- Pending turn: dir_valid loads pend_dir and sets pend_v in any state. The last request wins. If dir_valid coincides with a commit that consumes the pending turn, the new request is kept.
- Target computation: step from (x_loc,y_loc) in candidate direction cand.
  - x: WIDTH+1 wraps to 1; 0 wraps to WIDTH.
  - y: HEIGHT+1 wraps to 1; 0 wraps to HEIGHT.
  - Stored coordinates never leave 1..WIDTH and 1..HEIGHT.
- FSM states: IDLE, QUERY, RETRY.
- IDLE, on tick:
  - if pend_v: cand=pend_dir, go to QUERY.
  - else if moving: cand=dir_cur, go to QUERY.
  - else: stay in IDLE; no pulse.
- QUERY: wall_req=1, with wall_x/wall_y = target(cand) registered on entry and stable until ack. On wall_ack:
  - not blocked: commit. x/y <= target, dir_cur <= cand, moving <= 1, move_done pulses the next cycle. If cand came from the pending turn, pend_v clears. Go to IDLE.
  - blocked, cand from the pending turn, and moving=1 with dir_cur != cand: go to RETRY with cand=dir_cur. pend_v stays set, so the turn is buffered for cornering.
  - blocked otherwise: moving <= 0, go to IDLE. Position is unchanged. pend_v stays set if it was.
- RETRY: re-enter the query with the new cand and new target; wall_req deasserts for exactly one cycle between queries. On ack:
  - not blocked: commit as above, but pend_v is NOT cleared.
  - blocked: moving <= 0, go to IDLE.
- Latency: tick to move_done is 3 cycles with zero-wait ack (ack in the first wall_req cycle), or 5 cycles with a retry.
- A tick received while not in IDLE is dropped and pulses tick_drop.
- wall_ack outside QUERY/RETRY is ignored.

Optional Feature:
Macro SPRITE_ACK_TIMEOUT_EN.
- Defined: a counter runs while wall_req=1. If it reaches ACK_TIMEOUT with no ack, the query is treated as blocked, ack_err pulses for 1 cycle, and the FSM follows the blocked path.
- Undefined: the block waits for wall_ack indefinitely, and ack_err is tied to 0.

Test Plan:
- Reset then idle: release reset_n, give 3 ticks with no dir -> x=46, y=7, moving=0, wall_req never asserted, no move_done.
- Basic move: dir_valid dir=3, tick, ack unblocked -> wall_x=47, wall_y=7; x=47, move_done 1 pulse, moving=1. A second tick with no new dir queries (48,7) and commits.
- Wrap-around: start, then steer left to x=1, tick, ack clear -> queried x=96, x_loc=96. Up from y=1 -> y=72. Down from y=72 -> y=1.
- Buffered corner: moving right at (50,7); request up, ack blocked; the retry query (51,7) clears -> x=51, dir_cur=3, pend_v held. Next tick queries (51,6), clear -> y=6, dir_cur=0.
- Dead stop and drop: moving left, tick, ack blocked, no pending turn -> moving=0, position unchanged. A tick during QUERY -> tick_drop pulse. start during QUERY -> x=46, y=7, wall_req low the next cycle.
- Timeout (SPRITE_ACK_TIMEOUT_EN defined): tick with ack withheld -> ack_err after 15 wall_req cycles, moving=0. With the macro undefined, wall_req stays high for at least 100 cycles.

Source files
------------

// File: rtl/sprite_mover.sv
// sprite_mover: position engine for one sprite.
// Holds the current heading and one buffered turn request. On each move tick
// it asks the maze wall lookup (req/ack) whether the target cell is free, then
// commits the step. Stepping off one edge of the playfield wraps to the other.
// Build option: define SPRITE_ACK_TIMEOUT_EN to stop waiting on a wall query
// after ACK_TIMEOUT wall_req cycles. The query is then treated as blocked and
// ack_err pulses. Without it the block waits for wall_ack indefinitely.

module sprite_mover #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 72,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int X_START     = 46,
    parameter int Y_START     = 7,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          tick,
    input  logic          dir_valid,
    input  logic [1:0]    dir_in,
    output logic          wall_req,
    output logic [XW-1:0] wall_x,
    output logic [YW-1:0] wall_y,
    input  logic          wall_ack,
    input  logic          wall_blocked,
    output logic [XW-1:0] x_loc,
    output logic [YW-1:0] y_loc,
    output logic [1:0]    dir_cur,
    output logic          moving,
    output logic          move_done,
    output logic          tick_drop,
    output logic          ack_err
);

    localparam logic [XW-1:0] X_INIT = XW'(X_START);
    localparam logic [YW-1:0] Y_INIT = YW'(Y_START);
    localparam logic [XW-1:0] X_MAX  = XW'(WIDTH);
    localparam logic [YW-1:0] Y_MAX  = YW'(HEIGHT);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        RETRY = 2'd2
    } state_t;

    state_t        state_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [1:0]    dir_reg;
    logic          moving_reg;
    logic          pend_v_reg;
    logic [1:0]    pend_dir_reg;
    logic [1:0]    cand_reg;
    logic          cand_pend_reg;
    logic          wall_req_reg;
    logic [XW-1:0] wall_x_reg;
    logic [YW-1:0] wall_y_reg;
    logic          commit_reg;
    logic          move_done_reg;
    logic          tick_drop_reg;

    // One-step neighbour of the current cell in each of the four headings
    // (0 up, 1 down, 2 left, 3 right), already wrapped into 1..WIDTH/HEIGHT.
    logic [XW-1:0] tgt_x [4];
    logic [YW-1:0] tgt_y [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tgt
            if (gi == 2) begin : g_x_left
                assign tgt_x[gi] = (x_reg == X_ONE) ? X_MAX : x_reg - X_ONE;
            end else if (gi == 3) begin : g_x_right
                assign tgt_x[gi] = (x_reg == X_MAX) ? X_ONE : x_reg + X_ONE;
            end else begin : g_x_hold
                assign tgt_x[gi] = x_reg;
            end

            if (gi == 0) begin : g_y_up
                assign tgt_y[gi] = (y_reg == Y_ONE) ? Y_MAX : y_reg - Y_ONE;
            end else if (gi == 1) begin : g_y_down
                assign tgt_y[gi] = (y_reg == Y_MAX) ? Y_ONE : y_reg + Y_ONE;
            end else begin : g_y_hold
                assign tgt_y[gi] = y_reg;
            end
        end
    endgenerate

    // A buffered turn takes priority over continuing straight.
    logic [1:0] idle_cand;
    assign idle_cand = pend_v_reg ? pend_dir_reg : dir_reg;

    // Query outcome seen this cycle: a real ack, or (optionally) a timeout.
    logic timeout_hit;
    logic resp_valid;
    logic resp_blocked;

`ifdef SPRITE_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             ack_err_reg;

    assign timeout_hit = wall_req_reg && !wall_ack &&
                         (wait_cnt_reg == CNT_W'(ACK_TIMEOUT - 1));

    // Count wall_req cycles of the current query; flag the one that expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg <= '0;
            ack_err_reg  <= 1'b0;
        end else if (start) begin
            wait_cnt_reg <= '0;
            ack_err_reg  <= 1'b0;
        end else begin
            ack_err_reg <= timeout_hit;
            if (!wall_req_reg || wall_ack || timeout_hit) begin
                wait_cnt_reg <= '0;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
        end
    end

    assign ack_err = ack_err_reg;
`else
    assign timeout_hit = 1'b0;
    // No timeout in this build. The compare is constant 0 for any legal
    // ACK_TIMEOUT, so ack_err stays low and the parameter list stays the same.
    assign ack_err = (ACK_TIMEOUT < 0);
`endif

    assign resp_valid   = wall_req_reg && (wall_ack || timeout_hit);
    assign resp_blocked = wall_blocked || timeout_hit;

    // Main sequencer: turn buffer, wall handshake and position commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            x_reg         <= X_INIT;
            y_reg         <= Y_INIT;
            dir_reg       <= 2'd0;
            moving_reg    <= 1'b0;
            pend_v_reg    <= 1'b0;
            pend_dir_reg  <= 2'd0;
            cand_reg      <= 2'd0;
            cand_pend_reg <= 1'b0;
            wall_req_reg  <= 1'b0;
            wall_x_reg    <= X_INIT;
            wall_y_reg    <= Y_INIT;
            commit_reg    <= 1'b0;
            move_done_reg <= 1'b0;
            tick_drop_reg <= 1'b0;
        end else if (start) begin
            state_reg     <= IDLE;
            x_reg         <= X_INIT;
            y_reg         <= Y_INIT;
            dir_reg       <= 2'd0;
            moving_reg    <= 1'b0;
            pend_v_reg    <= 1'b0;
            pend_dir_reg  <= 2'd0;
            cand_reg      <= 2'd0;
            cand_pend_reg <= 1'b0;
            wall_req_reg  <= 1'b0;
            wall_x_reg    <= X_INIT;
            wall_y_reg    <= Y_INIT;
            commit_reg    <= 1'b0;
            move_done_reg <= 1'b0;
            tick_drop_reg <= 1'b0;
        end else begin
            // move_done trails the position update by one cycle.
            commit_reg    <= 1'b0;
            move_done_reg <= commit_reg;
            tick_drop_reg <= 1'b0;

            // The latest request always overwrites the buffer.
            if (dir_valid) begin
                pend_v_reg   <= 1'b1;
                pend_dir_reg <= dir_in;
            end

            case (state_reg)
                IDLE: begin
                    if (tick && (pend_v_reg || moving_reg)) begin
                        cand_reg      <= idle_cand;
                        cand_pend_reg <= pend_v_reg;
                        wall_x_reg    <= tgt_x[idle_cand];
                        wall_y_reg    <= tgt_y[idle_cand];
                        wall_req_reg  <= 1'b1;
                        state_reg     <= QUERY;
                    end
                end

                QUERY: begin
                    tick_drop_reg <= tick;
                    if (resp_valid) begin
                        wall_req_reg <= 1'b0;
                        if (!resp_blocked) begin
                            x_reg      <= wall_x_reg;
                            y_reg      <= wall_y_reg;
                            dir_reg    <= cand_reg;
                            moving_reg <= 1'b1;
                            commit_reg <= 1'b1;
                            // A request arriving on this very edge is kept.
                            if (cand_pend_reg && !dir_valid) begin
                                pend_v_reg <= 1'b0;
                            end
                            state_reg <= IDLE;
                        end else if (cand_pend_reg && moving_reg &&
                                     (dir_reg != cand_reg)) begin
                            // Turn not possible yet: keep going straight and
                            // leave the turn buffered for the next corner.
                            cand_reg      <= dir_reg;
                            cand_pend_reg <= 1'b0;
                            state_reg     <= RETRY;
                        end else begin
                            moving_reg <= 1'b0;
                            state_reg  <= IDLE;
                        end
                    end
                end

                RETRY: begin
                    tick_drop_reg <= tick;
                    if (!wall_req_reg) begin
                        // Gap cycle between the two queries: load the new target.
                        wall_x_reg   <= tgt_x[cand_reg];
                        wall_y_reg   <= tgt_y[cand_reg];
                        wall_req_reg <= 1'b1;
                    end else if (resp_valid) begin
                        wall_req_reg <= 1'b0;
                        state_reg    <= IDLE;
                        if (!resp_blocked) begin
                            x_reg      <= wall_x_reg;
                            y_reg      <= wall_y_reg;
                            dir_reg    <= cand_reg;
                            moving_reg <= 1'b1;
                            commit_reg <= 1'b1;
                        end else begin
                            moving_reg <= 1'b0;
                        end
                    end
                end

                default: begin
                    wall_req_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign wall_req  = wall_req_reg;
    assign wall_x    = wall_x_reg;
    assign wall_y    = wall_y_reg;
    assign x_loc     = x_reg;
    assign y_loc     = y_reg;
    assign dir_cur   = dir_reg;
    assign moving    = moving_reg;
    assign move_done = move_done_reg;
    assign tick_drop = tick_drop_reg;

endmodule

// File: tb/tb_sprite_mover.sv
// Testbench for sprite_mover: directed scenarios plus a randomized walk
// through a random maze, checked against a cell-level movement model.

module tb_sprite_mover;

    localparam int W  = 96;
    localparam int H  = 72;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          tick = 1'b0;
    logic          dir_valid = 1'b0;
    logic [1:0]    dir_in = 2'd0;
    logic          wall_req;
    logic [XW-1:0] wall_x;
    logic [YW-1:0] wall_y;
    logic          wall_ack = 1'b0;
    logic          wall_blocked = 1'b0;
    logic [XW-1:0] x_loc;
    logic [YW-1:0] y_loc;
    logic [1:0]    dir_cur;
    logic          moving;
    logic          move_done;
    logic          tick_drop;
    logic          ack_err;

    always #5 clk = ~clk;

    sprite_mover #(
        .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW),
        .X_START(46), .Y_START(7), .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir_in(dir_in),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_blocked(wall_blocked),
        .x_loc(x_loc), .y_loc(y_loc), .dir_cur(dir_cur), .moving(moving),
        .move_done(move_done), .tick_drop(tick_drop), .ack_err(ack_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observations captured by run_tick for one tick transaction.
    int            obs_nq;
    logic [XW-1:0] obs_qx [2];
    logic [YW-1:0] obs_qy [2];
    int            obs_qstart [2];
    int            obs_ackc [2];
    int            obs_done_cyc;
    int            obs_done_cnt;
    int            obs_drop_cnt;

    bit maze [W+2][H+2];

    // Neighbouring cell in heading d with tunnel wrap.
    function automatic void step(input int x, input int y, input int d,
                                 output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            0:       ny = y - 1;
            1:       ny = y + 1;
            2:       nx = x - 1;
            default: nx = x + 1;
        endcase
        if (nx > W) nx -= W;
        if (nx < 1) nx += W;
        if (ny > H) ny -= H;
        if (ny < 1) ny += H;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_in = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    // Issue one tick and act as the wall lookup. Query k gets its ack after
    // 'delay' wall_req cycles with blocked = blk0/blk1. Optionally inject a
    // dir_valid or an extra tick on a given cycle. Cycle 0 is the tick cycle.
    task automatic run_tick(input bit blk0, input bit blk1, input int delay,
                            input int dv_at, input logic [1:0] dv_d,
                            input int tick_at);
        int  wait_cnt;
        bit  prev_req;
        obs_nq = 0;
        obs_done_cyc = -1;
        obs_done_cnt = 0;
        obs_drop_cnt = 0;
        obs_qstart[0] = -1; obs_qstart[1] = -1;
        obs_ackc[0] = -1;   obs_ackc[1] = -1;
        obs_qx[0] = '0; obs_qx[1] = '0; obs_qy[0] = '0; obs_qy[1] = '0;
        wait_cnt = 0;
        prev_req = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 12 + 2 * delay; c++) begin
            tick = (c == tick_at);
            dir_valid = (c == dv_at);
            dir_in = dv_d;
            wall_ack = 1'b0;
            wall_blocked = 1'b0;
            if (move_done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = c;
            end
            if (tick_drop === 1'b1) obs_drop_cnt++;
            if (wall_req === 1'b1) begin
                if (!prev_req) begin
                    if (obs_nq < 2) begin
                        obs_qx[obs_nq] = wall_x;
                        obs_qy[obs_nq] = wall_y;
                        obs_qstart[obs_nq] = c;
                    end
                    obs_nq++;
                    wait_cnt = 0;
                end
                if (wait_cnt == delay && obs_nq <= 2) begin
                    wall_ack = 1'b1;
                    wall_blocked = (obs_nq == 1) ? blk0 : blk1;
                    obs_ackc[obs_nq-1] = c;
                end
                wait_cnt++;
            end
            prev_req = (wall_req === 1'b1);
            @(negedge clk);
        end
        tick = 1'b0;
        dir_valid = 1'b0;
        wall_ack = 1'b0;
        wall_blocked = 1'b0;
    endtask

    task automatic test_reset();
        int nq_total;
        int done_total;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (x_loc !== 10'd46 || y_loc !== 9'd7 || dir_cur !== 2'd0 || moving !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got x=%0d y=%0d dir=%0d mov=%b, expected x=46 y=7 dir=0 mov=0",
                     x_loc, y_loc, dir_cur, moving);
        end
        n_checks++;
        if (wall_req !== 1'b0 || move_done !== 1'b0 || tick_drop !== 1'b0 || ack_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pulses: got req=%b done=%b drop=%b err=%b, expected all 0",
                     wall_req, move_done, tick_drop, ack_err);
        end
        reset_n = 1'b1;
        @(negedge clk);
        nq_total = 0;
        done_total = 0;
        for (int i = 0; i < 3; i++) begin
            run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
            nq_total += obs_nq;
            done_total += obs_done_cnt;
        end
        n_checks++;
        if (nq_total != 0 || done_total != 0) begin
            n_errors++;
            $display("FAIL idle_ticks: got queries=%0d move_done=%0d, expected 0 and 0", nq_total, done_total);
        end
        n_checks++;
        if (x_loc !== 10'd46 || y_loc !== 9'd7 || moving !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_pos: got (%0d,%0d) mov=%b, expected (46,7) mov=0", x_loc, y_loc, moving);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_move();
        set_dir(2'd3);
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_nq != 1 || obs_qx[0] !== 10'd47 || obs_qy[0] !== 9'd7) begin
            n_errors++;
            $display("FAIL basic_query: got n=%0d (%0d,%0d), expected n=1 (47,7)", obs_nq, obs_qx[0], obs_qy[0]);
        end
        n_checks++;
        if (x_loc !== 10'd47 || y_loc !== 9'd7 || moving !== 1'b1 || dir_cur !== 2'd3) begin
            n_errors++;
            $display("FAIL basic_commit: got (%0d,%0d) mov=%b dir=%0d, expected (47,7) mov=1 dir=3",
                     x_loc, y_loc, moving, dir_cur);
        end
        n_checks++;
        if (obs_done_cnt != 1 || obs_done_cyc != 3) begin
            n_errors++;
            $display("FAIL basic_latency: got pulses=%0d at cycle %0d, expected 1 at cycle 3",
                     obs_done_cnt, obs_done_cyc);
        end
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_nq != 1 || obs_qx[0] !== 10'd48 || obs_qy[0] !== 9'd7 || x_loc !== 10'd48) begin
            n_errors++;
            $display("FAIL basic_second: got n=%0d q=(%0d,%0d) x=%0d, expected n=1 q=(48,7) x=48",
                     obs_nq, obs_qx[0], obs_qy[0], x_loc);
        end
        $display("test_basic_move done");
    endtask

    task automatic test_wrap();
        do_start();
        set_dir(2'd2);
        for (int i = 0; i < 45; i++) run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (x_loc !== 10'd1 || y_loc !== 9'd7) begin
            n_errors++;
            $display("FAIL wrap_walk: got (%0d,%0d), expected (1,7)", x_loc, y_loc);
        end
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_qx[0] !== 10'd96 || x_loc !== 10'd96) begin
            n_errors++;
            $display("FAIL wrap_left: got query x=%0d x_loc=%0d, expected 96 and 96", obs_qx[0], x_loc);
        end
        set_dir(2'd0);
        for (int i = 0; i < 6; i++) run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_qy[0] !== 9'd72 || y_loc !== 9'd72 || x_loc !== 10'd96) begin
            n_errors++;
            $display("FAIL wrap_up: got query y=%0d loc=(%0d,%0d), expected 72 and (96,72)", obs_qy[0], x_loc, y_loc);
        end
        set_dir(2'd1);
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_qy[0] !== 9'd1 || y_loc !== 9'd1) begin
            n_errors++;
            $display("FAIL wrap_down: got query y=%0d y_loc=%0d, expected 1 and 1", obs_qy[0], y_loc);
        end
        $display("test_wrap done");
    endtask

    task automatic test_corner();
        do_start();
        set_dir(2'd3);
        for (int i = 0; i < 4; i++) run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        set_dir(2'd0);
        run_tick(1'b1, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_nq != 2 || obs_qx[0] !== 10'd50 || obs_qy[0] !== 9'd6 ||
            obs_qx[1] !== 10'd51 || obs_qy[1] !== 9'd7) begin
            n_errors++;
            $display("FAIL corner_queries: got n=%0d (%0d,%0d) (%0d,%0d), expected n=2 (50,6) (51,7)",
                     obs_nq, obs_qx[0], obs_qy[0], obs_qx[1], obs_qy[1]);
        end
        n_checks++;
        if (obs_qstart[1] - obs_ackc[0] != 2) begin
            n_errors++;
            $display("FAIL corner_gap: got %0d cycles between ack and retry, expected 2",
                     obs_qstart[1] - obs_ackc[0]);
        end
        n_checks++;
        if (x_loc !== 10'd51 || y_loc !== 9'd7 || dir_cur !== 2'd3 || obs_done_cyc != 5) begin
            n_errors++;
            $display("FAIL corner_retry: got (%0d,%0d) dir=%0d done@%0d, expected (51,7) dir=3 done@5",
                     x_loc, y_loc, dir_cur, obs_done_cyc);
        end
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_qx[0] !== 10'd51 || obs_qy[0] !== 9'd6 || y_loc !== 9'd6 || dir_cur !== 2'd0) begin
            n_errors++;
            $display("FAIL corner_turn: got q=(%0d,%0d) y=%0d dir=%0d, expected q=(51,6) y=6 dir=0",
                     obs_qx[0], obs_qy[0], y_loc, dir_cur);
        end
        // A request landing on the commit edge survives the consumed turn.
        set_dir(2'd0);
        run_tick(1'b0, 1'b0, 0, 1, 2'd3, -1);
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        n_checks++;
        if (obs_qx[0] !== 10'd52 || obs_qy[0] !== 9'd5 || dir_cur !== 2'd3) begin
            n_errors++;
            $display("FAIL corner_keep_req: got q=(%0d,%0d) dir=%0d, expected q=(52,5) dir=3",
                     obs_qx[0], obs_qy[0], dir_cur);
        end
        $display("test_corner done");
    endtask

    task automatic test_stop_drop();
        int bad;
        do_start();
        set_dir(2'd2);
        run_tick(1'b0, 1'b0, 0, -1, 2'd0, -1);
        run_tick(1'b1, 1'b0, 0, -1, 2'd0, 1);
        n_checks++;
        if (obs_nq != 1 || x_loc !== 10'd45 || y_loc !== 9'd7 || moving !== 1'b0 || obs_done_cnt != 0) begin
            n_errors++;
            $display("FAIL stop_blocked: got n=%0d (%0d,%0d) mov=%b done=%0d, expected n=1 (45,7) mov=0 done=0",
                     obs_nq, x_loc, y_loc, moving, obs_done_cnt);
        end
        n_checks++;
        if (obs_drop_cnt != 1) begin
            n_errors++;
            $display("FAIL tick_drop: got %0d pulses, expected 1", obs_drop_cnt);
        end
        // start while a query is outstanding, then a late ack.
        set_dir(2'd2);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n_checks++;
        if (wall_req !== 1'b1 || wall_x !== 10'd44) begin
            n_errors++;
            $display("FAIL start_pre: got req=%b x=%0d, expected req=1 x=44", wall_req, wall_x);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (wall_req !== 1'b0 || x_loc !== 10'd46 || y_loc !== 9'd7) begin
            n_errors++;
            $display("FAIL start_abort: got req=%b (%0d,%0d), expected req=0 (46,7)", wall_req, x_loc, y_loc);
        end
        wall_ack = 1'b1;
        wall_blocked = 1'b0;
        @(negedge clk);
        wall_ack = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (move_done !== 1'b0 || x_loc !== 10'd46 || moving !== 1'b0 || wall_req !== 1'b0) bad++;
            @(negedge clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL late_ack: got %0d cycles reacting to a stale ack, expected 0", bad);
        end
        $display("test_stop_drop done");
    endtask

    task automatic test_timeout();
        int req_cycles;
        int err_cnt;
        int err_cyc;
        do_start();
        set_dir(2'd3);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        req_cycles = 0;
        err_cnt = 0;
        err_cyc = -1;
`ifdef SPRITE_ACK_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            if (wall_req === 1'b1) req_cycles++;
            if (ack_err === 1'b1) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = c;
            end
            @(negedge clk);
        end
        n_checks++;
        if (req_cycles != 15 || err_cnt != 1 || err_cyc != 16) begin
            n_errors++;
            $display("FAIL timeout: got req_cycles=%0d err_pulses=%0d at %0d, expected 15, 1 at 16",
                     req_cycles, err_cnt, err_cyc);
        end
        n_checks++;
        if (moving !== 1'b0 || x_loc !== 10'd46) begin
            n_errors++;
            $display("FAIL timeout_state: got mov=%b x=%0d, expected mov=0 x=46", moving, x_loc);
        end
`else
        for (int c = 1; c <= 100; c++) begin
            if (wall_req === 1'b1) req_cycles++;
            if (ack_err !== 1'b0) err_cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (req_cycles != 100 || err_cnt != 0) begin
            n_errors++;
            $display("FAIL no_timeout: got req_cycles=%0d ack_err=%0d, expected 100 and 0", req_cycles, err_cnt);
        end
        do_start();
        n_checks++;
        if (wall_req !== 1'b0 || x_loc !== 10'd46) begin
            n_errors++;
            $display("FAIL no_timeout_abort: got req=%b x=%0d, expected req=0 x=46", wall_req, x_loc);
        end
`endif
        $display("test_timeout done");
    endtask

    task automatic test_random();
        int m_x, m_y, m_dir, m_pd;
        bit m_mov, m_pv;
        int r, d, delay, c, t1x, t1y, t2x, t2y, e_nq, e_done;
        bit from_p, b0, b1;
        int bad;
        for (int i = 0; i < W + 2; i++)
            for (int j = 0; j < H + 2; j++)
                maze[i][j] = ($urandom_range(0, 99) < 25);
        do_start();
        m_x = 46; m_y = 7; m_dir = 0; m_mov = 0; m_pv = 0; m_pd = 0;
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 3);
            if (r != 0) begin
                d = $urandom_range(0, 3);
                set_dir(2'(d));
                m_pv = 1; m_pd = d;
                if (r == 3) begin
                    d = $urandom_range(0, 3);
                    set_dir(2'(d));
                    m_pd = d;
                end
            end
            delay = $urandom_range(0, 2);
            e_nq = 0; e_done = -1; b0 = 0; b1 = 0;
            t1x = 0; t1y = 0; t2x = 0; t2y = 0;
            if (m_pv || m_mov) begin
                from_p = m_pv;
                c = m_pv ? m_pd : m_dir;
                step(m_x, m_y, c, t1x, t1y);
                b0 = maze[t1x][t1y];
                e_nq = 1;
                if (!b0) begin
                    m_x = t1x; m_y = t1y; m_dir = c; m_mov = 1;
                    if (from_p) m_pv = 0;
                    e_done = 3 + delay;
                end else if (from_p && m_mov && m_dir != c) begin
                    step(m_x, m_y, m_dir, t2x, t2y);
                    b1 = maze[t2x][t2y];
                    e_nq = 2;
                    if (!b1) begin
                        m_x = t2x; m_y = t2y;
                        e_done = 5 + 2 * delay;
                    end else begin
                        m_mov = 0;
                    end
                end else begin
                    m_mov = 0;
                end
            end
            run_tick(b0, b1, delay, -1, 2'd0, -1);
            $display("txn %0d: queries=%0d pos=(%0d,%0d) dir=%0d mov=%b done@%0d",
                     n, obs_nq, x_loc, y_loc, dir_cur, moving, obs_done_cyc);
            bad = 0;
            if (obs_nq != e_nq) bad |= 1;
            if (e_nq >= 1 && (obs_qx[0] !== XW'(t1x) || obs_qy[0] !== YW'(t1y))) bad |= 2;
            if (e_nq == 2 && (obs_qx[1] !== XW'(t2x) || obs_qy[1] !== YW'(t2y))) bad |= 4;
            if (x_loc !== XW'(m_x) || y_loc !== YW'(m_y) || dir_cur !== 2'(m_dir) || moving !== m_mov) bad |= 8;
            if (obs_done_cyc != e_done || obs_done_cnt != ((e_done < 0) ? 0 : 1) || obs_drop_cnt != 0) bad |= 16;
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL rand_txn %0d (code %0d): got n=%0d q0=(%0d,%0d) q1=(%0d,%0d) pos=(%0d,%0d) dir=%0d mov=%b done@%0d; expected n=%0d q0=(%0d,%0d) q1=(%0d,%0d) pos=(%0d,%0d) dir=%0d mov=%b done@%0d",
                         n, bad, obs_nq, obs_qx[0], obs_qy[0], obs_qx[1], obs_qy[1], x_loc, y_loc, dir_cur, moving,
                         obs_done_cyc, e_nq, t1x, t1y, t2x, t2y, m_x, m_y, m_dir, m_mov, e_done);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic_move();
        test_wrap();
        test_corner();
        test_stop_drop();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within 2 ms (checks=%0d errors=%0d)", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
